// File: rtl/rv32_cpu_top_verify.sv
// Single-cycle RV32I core with internal register file and data memory.
// The instruction memory is external. A debug read port exposes x[ra3]
// combinationally so that each committed instruction can be checked the
// cycle after it executes.
module rv32_cpu_top_verify #(
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_out,
  input  logic [4:0]  ra3,
  output logic [31:0] rd3
);

  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Architectural state
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  // Datapath
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc_plus4;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [AW-1:0] mem_idx;
  logic [31:0] next_pc;
  logic [31:0] wb_data;
  logic        reg_we;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] st_data;
  logic        unused_addr_bits;

  // Integer ALU shared by register-register and register-immediate forms.
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic sub_sra);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    a_s = $signed(a);
    b_s = $signed(b);
    case (f3)
      3'b000:  return sub_sra ? (a - b) : (a + b);
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, (a_s < b_s)};
      3'b011:  return {31'b0, (a < b)};
      3'b100:  return a ^ b;
      3'b101:  return sub_sra ? $unsigned(a_s >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // Branch condition; reserved funct3 encodings never take the branch.
  function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    a_s = $signed(a);
    b_s = $signed(b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return a_s < b_s;
      3'b101:  return a_s >= b_s;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Lane selection and extension of load data; low address bits beyond
  // the access size are ignored rather than trapped.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  assign opcode = imem_out[6:0];
  assign rd     = imem_out[11:7];
  assign funct3 = imem_out[14:12];
  assign rs1    = imem_out[19:15];
  assign rs2    = imem_out[24:20];
  assign alt    = imem_out[30];

  assign imm_i = {{20{imem_out[31]}}, imem_out[31:20]};
  assign imm_s = {{20{imem_out[31]}}, imem_out[31:25], imem_out[11:7]};
  assign imm_b = {{19{imem_out[31]}}, imem_out[31], imem_out[7], imem_out[30:25],
                  imem_out[11:8], 1'b0};
  assign imm_u = {imem_out[31:12], 12'b0};
  assign imm_j = {{11{imem_out[31]}}, imem_out[31], imem_out[19:12], imem_out[20],
                  imem_out[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign rd3      = (ra3 == 5'd0) ? 32'd0 : regs[ra3];
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign mem_addr         = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign mem_idx          = mem_addr[AW+1:2];
  assign mem_rdata        = dmem[mem_idx];
  assign unused_addr_bits = ^mem_addr[31:AW+2];

  // Decode and execute: writeback value, store lanes and next PC.
  always_comb begin
    next_pc = pc_plus4;
    wb_data = 32'd0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    mem_be  = 4'b0000;
    st_data = rs2_val;
    case (opcode)
      OP_LUI: begin
        reg_we  = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        reg_we  = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        reg_we  = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          reg_we  = 1'b1;
          wb_data = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (br_taken(rs1_val, rs2_val, funct3)) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          reg_we  = 1'b1;
          wb_data = load_ext(mem_rdata, mem_addr[1:0], funct3);
        end
      end
      OP_STORE: begin
        case (funct3)
          3'b000: begin
            mem_we  = 1'b1;
            st_data = {4{rs2_val[7:0]}};
            case (mem_addr[1:0])
              2'b00:   mem_be = 4'b0001;
              2'b01:   mem_be = 4'b0010;
              2'b10:   mem_be = 4'b0100;
              default: mem_be = 4'b1000;
            endcase
          end
          3'b001: begin
            mem_we  = 1'b1;
            st_data = {2{rs2_val[15:0]}};
            mem_be  = mem_addr[1] ? 4'b1100 : 4'b0011;
          end
          3'b010: begin
            mem_we  = 1'b1;
            mem_be  = 4'b1111;
          end
          default: mem_we = 1'b0;
        endcase
      end
      OP_IMM: begin
        reg_we  = 1'b1;
        wb_data = alu(rs1_val, imm_i, funct3, (funct3 == 3'b101) && alt);
      end
      OP_REG: begin
        reg_we  = 1'b1;
        wb_data = alu(rs1_val, rs2_val, funct3, alt);
      end
      default: begin
        next_pc = pc_plus4;
      end
    endcase
  end

  // Program counter: reset wins over any jump or branch.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  // Register file: cleared on reset, x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (reg_we && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  // Data memory byte-lane writes; contents survive reset but a store in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) dmem[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32_cpu_top_verify.sv
// Directed instruction-level bench for rv32_cpu_top_verify. Small programs
// are placed in a bench-side instruction ROM; each result is compared
// against hand-computed values through the debug register port.
module tb_rv32_cpu_top_verify;

  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPR  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_out;
  logic [4:0]  ra3 = 5'd0;
  logic [31:0] rd3;
  logic [31:0] prog [128];
  int          n_cmp = 0;
  int          n_bad = 0;

  rv32_cpu_top_verify #(.DMEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_out(imem_out),
    .ra3(ra3), .rd3(rd3)
  );

  always #5 clk = ~clk;

  // Instruction ROM; anything outside the loaded window reads as a NOP.
  always_comb begin
    imem_out = 32'h0000_0013;
    if (imem_addr < 32'd512) imem_out = prog[imem_addr[8:2]];
  end

  function automatic logic [31:0] e_i(input logic [31:0] imm, input logic [31:0] rs1,
                                      input logic [31:0] f3, input logic [31:0] rd,
                                      input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] e_r(input logic [31:0] f7, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [31:0] f3,
                                      input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
  endfunction

  function automatic logic [31:0] e_s(input logic [31:0] imm, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], ST};
  endfunction

  function automatic logic [31:0] e_b(input logic [31:0] imm, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], BR};
  endfunction

  function automatic logic [31:0] e_u(input logic [31:0] imm20, input logic [31:0] rd);
    return {imm20[19:0], rd[4:0], LUI};
  endfunction

  function automatic logic [31:0] e_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], JAL};
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    ra3 = r;
    #1;
    expect_eq(tag, rd3, exp);
  endtask

  task automatic run_until(input string tag, input logic [31:0] addr, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (imem_addr == addr) break;
      step();
    end
    expect_eq(tag, imem_addr, addr);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) prog[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Loop, store loop, LHU and LH sweep program
    clear_prog();
    prog[0] = e_i(32'h6f4, 0, 0, 1, OPI);
    prog[1] = e_i(57, 0, 0, 2, OPI);
    prog[2] = e_i(0, 0, 0, 3, OPI);
    prog[3] = e_i(32'h6f4, 1, 0, 1, OPI);
    prog[4] = e_i(1, 3, 0, 3, OPI);
    prog[5] = e_b(8, 3, 2, 0);
    prog[6] = e_b(-12, 0, 0, 0);
    prog[7] = e_i(0, 0, 0, 4, OPI);
    prog[8] = e_i(32'h74, 0, 0, 5, OPI);
    prog[9] = e_s(0, 1, 4, 2);
    prog[10] = e_i(4, 4, 0, 4, OPI);
    prog[11] = e_b(-8, 4, 5, 1);
    prog[12] = e_i(0, 0, 0, 2, OPI);
    for (int k = 0; k < 29; k++) begin
      prog[13 + k] = e_i(k * 4, 2, 5, 3 + k, LD);
      prog[42 + k] = e_i(k * 4, 2, 1, 3 + k, LD);
    end
    prog[71] = e_i(2, 2, 1, 3, LD);
    prog[72] = e_j(0, 0);

    do_reset();
    expect_eq("reset_pc", imem_addr, 32'h0);
    chk_reg("reset_x1", 5'd1, 32'h0);
    chk_reg("reset_x31", 5'd31, 32'h0);

    run_until("loop_exit", 32'h1C, 400);
    chk_reg("loop_x1", 5'd1, 32'h0001_9348);
    chk_reg("loop_x3", 5'd3, 32'd57);

    run_until("store_loop_exit", 32'h34, 200);
    for (int k = 0; k < 29; k++) begin
      step();
      chk_reg($sformatf("lhu_x%0d", 3 + k), 5'(3 + k), 32'h0000_9348);
    end
    for (int k = 0; k < 29; k++) begin
      step();
      chk_reg($sformatf("lh_x%0d", 3 + k), 5'(3 + k), 32'hFFFF_9348);
    end
    step();
    chk_reg("lh_off2", 5'd3, 32'h0000_0001);

    // Byte and halfword lane access
    rst = 1'b1;
    clear_prog();
    prog[0] = e_u(32'h80818, 1);
    prog[1] = e_i(32'h283, 1, 0, 1, OPI);
    prog[2] = e_s(32'h10, 1, 0, 2);
    prog[3] = e_i(32'h13, 0, 0, 2, LD);
    prog[4] = e_i(32'h10, 0, 4, 3, LD);
    prog[5] = e_i(32'h7F, 0, 0, 4, OPI);
    prog[6] = e_s(32'h11, 4, 0, 0);
    prog[7] = e_i(32'h10, 0, 2, 5, LD);
    prog[8] = e_j(0, 0);
    do_reset();
    step();
    step();
    chk_reg("lui_addi_x1", 5'd1, 32'h8081_8283);
    step();
    step();
    chk_reg("lb_sign", 5'd2, 32'hFFFF_FF80);
    step();
    chk_reg("lbu_zero", 5'd3, 32'h0000_0083);
    step();
    step();
    step();
    chk_reg("sb_then_lw", 5'd5, 32'h8081_7F83);

    // x0 hardwiring and jumps
    rst = 1'b1;
    clear_prog();
    prog[0] = e_i(5, 0, 0, 0, OPI);
    prog[1] = e_j(32'h3C, 0);
    prog[16] = e_j(16, 1);
    prog[17] = e_j(0, 0);
    prog[20] = e_i(1, 1, 0, 0, JALR);
    do_reset();
    step();
    chk_reg("x0_write", 5'd0, 32'h0);
    step();
    expect_eq("jal_to_40", imem_addr, 32'h40);
    step();
    expect_eq("jal_pc", imem_addr, 32'h50);
    chk_reg("jal_link", 5'd1, 32'h44);
    step();
    expect_eq("jalr_pc", imem_addr, 32'h44);

    // Shifts, compares and signed/unsigned branches
    rst = 1'b1;
    clear_prog();
    prog[0] = e_u(32'h80000, 5);
    prog[1] = e_i(32'h404, 5, 5, 6, OPI);
    prog[2] = e_i(4, 5, 5, 6, OPI);
    prog[3] = e_r(0, 0, 5, 2, 7);
    prog[4] = e_r(0, 0, 5, 3, 7);
    prog[5] = e_b(8, 5, 0, 4);
    prog[7] = e_b(8, 5, 0, 7);
    prog[9] = e_b(8, 0, 5, 5);
    prog[11] = e_b(8, 5, 0, 6);
    prog[12] = e_r(32'h20, 5, 0, 0, 8);
    prog[13] = e_j(0, 0);
    do_reset();
    step();
    chk_reg("lui_x5", 5'd5, 32'h8000_0000);
    step();
    chk_reg("srai", 5'd6, 32'hF800_0000);
    step();
    chk_reg("srli", 5'd6, 32'h0800_0000);
    step();
    chk_reg("slt", 5'd7, 32'd1);
    step();
    chk_reg("sltu", 5'd7, 32'd0);
    step();
    expect_eq("blt_taken", imem_addr, 32'h1C);
    step();
    expect_eq("bgeu_taken", imem_addr, 32'h24);
    step();
    expect_eq("bge_taken", imem_addr, 32'h2C);
    step();
    expect_eq("bltu_not_taken", imem_addr, 32'h30);
    step();
    chk_reg("sub_neg_min", 5'd8, 32'h8000_0000);

    // Reset during a store suppresses the store
    rst = 1'b1;
    clear_prog();
    prog[0] = e_i(32'h55, 0, 0, 8, OPI);
    prog[1] = e_s(32'h10, 8, 0, 2);
    do_reset();
    step();
    expect_eq("pre_store_pc", imem_addr, 32'h4);
    rst = 1'b1;
    step();
    clear_prog();
    prog[0] = e_i(32'h10, 0, 2, 9, LD);
    prog[1] = e_j(0, 0);
    rst = 1'b0;
    expect_eq("midrst_pc", imem_addr, 32'h0);
    chk_reg("midrst_x8", 5'd8, 32'h0);
    step();
    chk_reg("store_suppressed", 5'd9, 32'h8081_7F83);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
